div_engine_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative divide engine among N requesters.
- Engine port: 10-bit dividend, 3-bit divisor, 20-bit quotient in 10.10 fixed point.
- Accepts one request at a time, drives the engine's in_valid handshake, and holds operands stable until the result returns.
- Routes the result back to the granted requester; a watchdog recovers a hung engine.

---
 rtl/div_engine_arbiter.sv | 163 ++++++++++++++++
 tb/tb_div_engine_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_engine_arbiter.sv
// Round-robin sequencer sharing one iterative 10.10 divide engine among N requesters.
// Optional macro DIV_ARB_ZERO_BYPASS_EN: divisor-zero requests are answered locally with an error.
module div_engine_arbiter #(
  parameter int N         = 4,
  parameter int ISSUE_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [10*N-1:0]   req_data_1,
  input  logic [3*N-1:0]    req_data_2,
  output logic [N-1:0]      resp_valid,
  output logic [19:0]       resp_data,
  output logic              resp_err,
  output logic              eng_in_valid,
  output logic [9:0]        eng_in_data_1,
  output logic [2:0]        eng_in_data_2,
  input  logic              eng_out_valid,
  input  logic [19:0]       eng_out_data,
  output logic              eng_rst,
  output logic              busy
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   last_q, last_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [9:0]      op1_q, op1_d;
  logic [2:0]      op2_q, op2_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [19:0]     data_q, data_d;
  logic            err_q, err_d;

  logic            found;
  logic [GW-1:0]   sel;
  logic [9:0]      sel_op1;
  logic [2:0]      sel_op2;

  // Rotating priority: first valid requester after the last one served.
  always_comb begin : p_sel
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  assign sel_op1 = req_data_1[10*int'(sel) +: 10];
  assign sel_op2 = req_data_2[3*int'(sel) +: 3];

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q;
    req_ready    = '0;
    resp_valid   = '0;
    resp_data    = '0;
    resp_err     = 1'b0;
    eng_in_valid = 1'b0;
    eng_rst      = 1'b0;
    case (state_q)
      IDLE: begin
        // No accept during reset: the requester would believe it was served.
        if (found && !rst) begin
          req_ready[sel] = 1'b1;
          gnt_d          = sel;
          op1_d          = sel_op1;
          op2_d          = sel_op2;
          cnt_d          = '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (sel_op2 == 3'd0) begin
            data_d  = 20'hFFFFF;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        eng_in_valid = 1'b1;
        if (cnt_q == 8'(ISSUE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (eng_out_valid) begin
          data_d  = eng_out_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          eng_rst = 1'b1;
          data_d  = 20'hFFFFF;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        resp_valid[gnt_q] = 1'b1;
        resp_data         = data_q;
        resp_err          = err_q;
        last_d            = gnt_q;
        state_d           = GAP;
      end
      GAP: begin
        // Engine may still be holding its done strobe from this operation.
        if (!eng_out_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GW'(N - 1);
      gnt_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Operands stay on the engine port from grant until the next grant.
  assign eng_in_data_1 = op1_q;
  assign eng_in_data_2 = op2_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_div_engine_arbiter.sv
// Directed bench for div_engine_arbiter: engine model, scoreboard queue, immediate-assert checks.
module tb_div_engine_arbiter;
  localparam int N = 4, ISSUE_CYC = 2, TIMEOUT = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic [N-1:0]  req_valid, req_ready, resp_valid;
  logic [10*N-1:0] req_data_1;
  logic [3*N-1:0]  req_data_2;
  logic [19:0]   resp_data, eng_out_data = '0;
  logic          resp_err, eng_in_valid, eng_out_valid = 1'b0, eng_rst, busy;
  logic [9:0]    eng_in_data_1;
  logic [2:0]    eng_in_data_2;

  div_engine_arbiter #(.N(N), .ISSUE_CYC(ISSUE_CYC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data_1(req_data_1), .req_data_2(req_data_2), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_err(resp_err), .eng_in_valid(eng_in_valid),
    .eng_in_data_1(eng_in_data_1), .eng_in_data_2(eng_in_data_2),
    .eng_out_valid(eng_out_valid), .eng_out_data(eng_out_data),
    .eng_rst(eng_rst), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] qf(input logic [9:0] a, input logic [2:0] b);
    logic [19:0] n;
    n = {a, 10'b0};
    if (b == 3'd0) return 20'hFFFFF;
    return n / {17'b0, b};
  endfunction

`ifdef DIV_ARB_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Requester agents: a request is pending while sent != accepted (unless withdrawn).
  int          sent [N] = '{default: 0};
  int          acc  [N] = '{default: 0};
  logic        wd   [N] = '{default: 1'b0};
  logic [9:0]  a_arr [N] = '{default: '0};
  logic [2:0]  b_arr [N] = '{default: '0};
  logic        hang = 1'b0;

  always_comb begin
    req_valid  = '0;
    req_data_1 = '0;
    req_data_2 = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = (sent[i] != acc[i]) && !wd[i];
      req_data_1[10*i +: 10] = a_arr[i];
      req_data_2[3*i +: 3]   = b_arr[i];
    end
  end

  always @(posedge clk)
    for (int i = 0; i < N; i++)
      if (req_ready[i]) acc[i] <= acc[i] + 1;

  // Engine model: result 25 cycles after in_valid falls, out_valid held 2 cycles.
  logic in_prev = 1'b0, hold = 1'b0;
  int   ecnt = 0;
  always @(posedge clk) begin
    in_prev <= eng_in_valid;
    if (rst || eng_rst) begin
      ecnt <= 0; hold <= 1'b0; eng_out_valid <= 1'b0;
    end else begin
      if (in_prev && !eng_in_valid && !hang) ecnt <= 25;
      else if (ecnt != 0) ecnt <= ecnt - 1;
      if (ecnt == 1) begin
        eng_out_valid <= 1'b1;
        eng_out_data  <= qf(eng_in_data_1, eng_in_data_2);
        hold          <= 1'b1;
      end else if (hold) hold <= 1'b0;
      else eng_out_valid <= 1'b0;
    end
  end

  typedef struct { int idx; logic [19:0] d; logic e; int iss; int kind; } exp_t;
  exp_t sb [$];
  int   grant_log [$];
  int   cyc = 0, rdy_cyc = 0, ov_rise = 0, iv_cnt = 0, since_iv = 0, rst_pulses = 0, rst_off = 0;
  logic ov_prev = 1'b0, have_op = 1'b0;
  logic [9:0]  cur_a = '0;
  logic [2:0]  cur_b = '0;
  logic [N-1:0] last_ready = '0, last_resp_v = '0;
  logic [19:0]  last_resp_d = '0;
  logic         last_resp_e = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    int g;
    cyc++;
    if (rst) begin
      sb.delete();
      have_op = 1'b0;
    end else begin
      chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      chk("resp_onehot", 64'($countones(resp_valid) <= 1), 64'd1);
      if (resp_valid == '0) chk("resp_idle_zero", {resp_err, resp_data}, 64'd0);
      if (busy && have_op) chk("op_stable", {eng_in_data_1, eng_in_data_2}, {cur_a, cur_b});
      if (eng_in_valid) begin iv_cnt++; since_iv = 0; end else since_iv++;
      if (eng_rst) begin rst_pulses++; rst_off = since_iv; end
      if (eng_out_valid && !ov_prev) ov_rise = cyc;
      if (req_ready != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        e.idx  = g;
        e.kind = hang ? 2 : ((BYPASS && b_arr[g] == 3'd0) ? 1 : 0);
        e.d    = (e.kind != 0) ? 20'hFFFFF : qf(a_arr[g], b_arr[g]);
        e.e    = (e.kind != 0);
        e.iss  = (e.kind == 1) ? 0 : ISSUE_CYC;
        sb.push_back(e);
        grant_log.push_back(g);
        have_op = 1'b1; cur_a = a_arr[g]; cur_b = b_arr[g];
        rdy_cyc = cyc; iv_cnt = 0; last_ready = req_ready;
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) chk("unexpected_resp", 64'(resp_valid), 64'd0);
        else begin
          e = sb.pop_front();
          chk("resp_idx", 64'(resp_valid), 64'(1 << e.idx));
          chk("resp_data", 64'(resp_data), 64'(e.d));
          chk("resp_err", 64'(resp_err), 64'(e.e));
          chk("issue_cycles", 64'(iv_cnt), 64'(e.iss));
          if (e.kind == 0) chk("resp_latency", 64'(cyc - ov_rise), 64'd1);
          if (e.kind == 1) chk("bypass_latency", 64'(cyc - rdy_cyc), 64'd1);
        end
        last_resp_v = resp_valid; last_resp_d = resp_data; last_resp_e = resp_err;
        have_op = 1'b0;
      end
      ov_prev = eng_out_valid;
    end
  end

  task automatic post(input int i, input logic [9:0] a, input logic [2:0] b);
    @(posedge clk); #1;
    a_arr[i] = a; b_arr[i] = b; sent[i] = sent[i] + 1;
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = (req_valid == '0) && (sb.size() == 0) && !busy;
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    int base, acc2, rbase;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {req_ready, resp_valid, resp_data, resp_err, eng_in_valid,
        eng_in_data_1, eng_in_data_2, eng_rst, busy}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Contention: all four pending, requester 0 twice.
    base = grant_log.size();
    @(posedge clk); #1;
    a_arr[0] = 10'd1000; b_arr[0] = 3'd7; a_arr[1] = 10'd100; b_arr[1] = 3'd3;
    a_arr[2] = 10'd513;  b_arr[2] = 3'd6; a_arr[3] = 10'd1;   b_arr[3] = 3'd1;
    sent[0] = sent[0] + 2;
    for (int i = 1; i < N; i++) sent[i] = sent[i] + 1;
    wait_idle("contention_done");
    for (int k = 0; k < 5; k++)
      chk("grant_order", 64'(grant_log.size() > base + k ? grant_log[base + k] : -1), 64'(exp_order[k]));

    // Single request 100/4 from requester 1.
    post(1, 10'd100, 3'd4);
    wait_idle("single_done");
    chk("single_ready", 64'(last_ready), 64'b0010);
    chk("single_resp_v", 64'(last_resp_v), 64'b0010);
    chk("single_data", 64'(last_resp_d), 64'h06400);
    chk("single_err", 64'(last_resp_e), 64'd0);

    // Withdrawn request: 2 drops as 3 raises while 1 is in flight.
    acc2 = acc[2];
    post(1, 10'd200, 3'd3);
    repeat (4) @(posedge clk);
    post(2, 10'd9, 3'd1);
    repeat (4) @(posedge clk);
    #1;
    wd[2] = 1'b1; a_arr[3] = 10'd77; b_arr[3] = 3'd5; sent[3] = sent[3] + 1;
    wait_idle("withdraw_done");
    chk("withdraw_grant", 64'(grant_log[grant_log.size() - 1]), 64'd3);
    chk("withdraw_prev", 64'(grant_log[grant_log.size() - 2]), 64'd1);
    chk("withdraw_no_accept", 64'(acc[2]), 64'(acc2));
    sent[2] = acc[2]; wd[2] = 1'b0;

    // Timeout: engine never answers.
    hang = 1'b1;
    rbase = rst_pulses;
    post(0, 10'd50, 3'd5);
    wait_idle("timeout_done");
    chk("eng_rst_pulses", 64'(rst_pulses - rbase), 64'd1);
    chk("eng_rst_cycle", 64'(rst_off), 64'(TIMEOUT));
    chk("timeout_data", 64'(last_resp_d), 64'hFFFFF);
    chk("timeout_err", 64'(last_resp_e), 64'd1);
    hang = 1'b0;
    post(0, 10'd50, 3'd5);
    wait_idle("after_timeout_done");
    chk("after_timeout_data", 64'(last_resp_d), 64'h02800);
    chk("after_timeout_err", 64'(last_resp_e), 64'd0);

    // Divide by zero 7/0.
    post(1, 10'd7, 3'd0);
    wait_idle("divzero_done");
    chk("divzero_data", 64'(last_resp_d), 64'hFFFFF);
    chk("divzero_err", 64'(last_resp_e), 64'(BYPASS));

    // Reset mid-WAIT, then a clean operation.
    post(2, 10'd300, 3'd7);
    for (int k = 0; k < 50 && !eng_in_valid; k++) @(negedge clk);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {req_ready, resp_valid, resp_data, resp_err, eng_in_valid,
        eng_in_data_1, eng_in_data_2, eng_rst, busy}, 64'd0);
    post(2, 10'd300, 3'd7);
    wait_idle("post_rst_done");
    chk("post_rst_data", 64'(last_resp_d), 64'h0AB6D);
    chk("post_rst_resp_v", 64'(last_resp_v), 64'b0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
